plic_cfg_sequencer: RTL and testbench
=====================================

PLIC_CFG_SEQUENCER -- requirements
Module: plic_cfg_sequencer

Interface
REQ-001 Parameter NUM_SRC, default 32, meaning number of PLIC sources including reserved source 0 (range 2..32).
REQ-002 Parameter PLIC_BASE, default 32'h0C00_0000, meaning PLIC base address on the AXI bus.
REQ-003 clk_i  input  1  sole clock; all state rising-edge.
REQ-004 rst_i  input  1  reset, asynchronous and active-high.
REQ-005 start_i  input  1  one-cycle request to run a configuration sequence.
REQ-006 en_mask_i  input  NUM_SRC  per-source enable for context 0 (bit 0 ignored).
REQ-007 prio_i  input  3  priority applied to every enabled source.
REQ-008 thresh_i  input  3  context-0 priority threshold.
REQ-009 busy_o  output  1  sequence in progress.
REQ-010 done_o  output  1  one-cycle pulse at sequence end (success or error).
REQ-011 err_o  output  1  sticky: last sequence aborted on a non-OKAY response.
REQ-012 m_axi_awaddr/awprot/awvalid/awready  out/out/out/in  32/3/1/1  AXI4-Lite write address channel.
REQ-013 m_axi_wdata/wstrb/wvalid/wready  out/out/out/in  32/4/1/1  AXI4-Lite write data channel.
REQ-014 m_axi_bresp/bvalid/bready  in/in/out  2/1/1  AXI4-Lite write response channel.

Function
REQ-015 start_i in IDLE latches en_mask_i, prio_i and thresh_i, clears err_o and sets index to 1; start_i while busy_o=1 is ignored.
REQ-016 Index 1..NUM_SRC-1 writes priority register: addr PLIC_BASE+4*index, data {29'b0, en_mask[index] ? prio : 3'b0}.
REQ-017 Index NUM_SRC writes enable word: addr PLIC_BASE+32'h0000_2000, data en_mask zero-extended to 32 bits with bit 0 forced to 0.
REQ-018 Index NUM_SRC+1 writes threshold: addr PLIC_BASE+32'h0020_0000, data {29'b0, thresh}.
REQ-019 FSM states IDLE, ISSUE, RESP; IDLE->ISSUE on accepted start_i; ISSUE->RESP when both AW and W have handshaken; RESP->ISSUE on bvalid with bresp=OKAY and index<NUM_SRC+1 (index increments); RESP->IDLE on last OKAY or any non-OKAY.
REQ-020 On entry to ISSUE, awvalid and wvalid assert in the same cycle; each deasserts the cycle after its own handshake; AW and W may complete in either order or together.
REQ-021 awaddr and wdata stay stable while their valid is high; awprot=3'b000, wstrb=4'hF constant.
REQ-022 bready is 1 only in RESP; bvalid in other states is ignored.
REQ-023 bresp other than 2'b00 sets err_o, skips remaining writes, and returns to IDLE.
REQ-024 done_o pulses for exactly one cycle on the RESP->IDLE transition; err_o is valid in that same cycle.
REQ-025 busy_o is 1 in ISSUE and RESP and 0 in IDLE.
REQ-026 A full successful sequence issues exactly NUM_SRC+1 writes, in index order, with at most one outstanding write.
REQ-027 Minimum latency per write is 2 cycles (ISSUE with both readies high, RESP with bvalid high).

Reset
REQ-028 Asserting rst_i, at any time including mid-transaction, forces IDLE with busy_o, done_o, err_o, awvalid, wvalid and bready all 0, and index=0.
REQ-029 After rst_i deasserts, the block issues no AXI traffic until the next start_i.

Structure
REQ-030 PLIC register offsets (priority base 0x0, enable ctx0 0x2000, threshold ctx0 0x20_0000), the AXI response code OKAY, and the FSM state enum belong in the shared plic package.
REQ-031 The block is a single module with no sub-modules; the AXI write port connects through the existing bus macros.

Verification
REQ-032 NUM_SRC=32, en_mask=32'h0000_0006, prio=3, thresh=1, always-ready slave -> 33 writes; 0x0C00_0004<-3, 0x0C00_0008<-3, 0x0C00_000C..0x0C00_007C<-0, 0x0C00_2000<-6, 0x0C20_0000<-1; done_o pulses once, err_o=0.
REQ-033 awready delayed 3 cycles, wready immediate (and the reverse) -> each valid drops independently after its handshake; no duplicated or missing write.
REQ-034 bresp=2'b10 on the 5th write -> exactly 5 writes issued, done_o pulses, err_o=1, busy_o=0; the next start_i clears err_o.
REQ-035 start_i pulsed during write 10 -> ignored; sequence completes with the original latched mask and priority.
REQ-036 rst_i asserted while awvalid=1 -> all outputs 0 the same cycle; no traffic until start_i.
REQ-037 en_mask bit 0 set -> enable-word data bit 0 = 0; source 0 priority never written.

Source files
------------

// File: rtl/plic_cfg_sequencer_pkg.sv
// Shared PLIC definitions: register offsets, AXI response codes and the
// configuration-sequencer state encoding.
package plic_cfg_sequencer_pkg;

  localparam logic [31:0] PLIC_PRIO_OFS   = 32'h0000_0000;
  localparam logic [31:0] PLIC_ENABLE_OFS = 32'h0000_2000;
  localparam logic [31:0] PLIC_THRESH_OFS = 32'h0020_0000;

  localparam logic [1:0]  AXI_RESP_OKAY   = 2'b00;
  localparam logic [2:0]  AXI_PROT_DATA   = 3'b000;
  localparam logic [3:0]  AXI_STRB_FULL   = 4'hF;

  // Wide enough for index NUM_SRC+1 with NUM_SRC up to 32.
  localparam int unsigned IDX_W = 6;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_RESP
  } state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_beat_t;

  function automatic logic [31:0] prio_addr(input logic [31:0]      base,
                                            input logic [IDX_W-1:0] idx);
    return base + PLIC_PRIO_OFS + {24'b0, idx, 2'b00};
  endfunction

endpackage

// File: rtl/plic_cfg_sequencer_if.sv
// AXI4-Lite write-only channel bundle used by the PLIC configuration sequencer.
interface plic_cfg_sequencer_if;

  logic [31:0] awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;

  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;

  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    input  awready, wready, bresp, bvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    output awready, wready, bresp, bvalid
  );

endinterface

// File: rtl/plic_cfg_sequencer.sv
// Walks a fixed list of PLIC register writes (source priorities, context-0
// enable word, context-0 threshold) over AXI4-Lite, one write outstanding.
module plic_cfg_sequencer
  import plic_cfg_sequencer_pkg::*;
#(
  parameter int unsigned NUM_SRC   = 32,
  parameter logic [31:0] PLIC_BASE = 32'h0C00_0000
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [NUM_SRC-1:0]   en_mask_i,
  input  logic [2:0]           prio_i,
  input  logic [2:0]           thresh_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o,
  plic_cfg_sequencer_if.master m_axi
);

  localparam logic [IDX_W-1:0] IDX_FIRST = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_EN    = IDX_W'(NUM_SRC);
  localparam logic [IDX_W-1:0] IDX_TH    = IDX_W'(NUM_SRC + 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q,   idx_d;
  logic [NUM_SRC-1:0] mask_q,  mask_d;
  logic [2:0]         prio_q,  prio_d;
  logic [2:0]         thresh_q, thresh_d;
  logic               awv_q,   awv_d;
  logic               wv_q,    wv_d;
  logic               done_q,  done_d;
  logic               err_q,   err_d;

  logic               aw_ok, w_ok;
  logic [63:0]        mask_ext;
  wr_beat_t           beat;

  // Address/data are pure functions of the latched config and index, so
  // they hold steady for as long as the index does (i.e. while valid is up).
  always_comb begin
    mask_ext  = 64'(mask_q);
    beat.addr = prio_addr(PLIC_BASE, idx_q);
    beat.data = {29'b0, mask_ext[idx_q] ? prio_q : 3'b000};
    if (idx_q == IDX_EN) begin
      beat.addr = PLIC_BASE + PLIC_ENABLE_OFS;
      beat.data = 32'(mask_q) & ~32'h1;
    end else if (idx_q == IDX_TH) begin
      beat.addr = PLIC_BASE + PLIC_THRESH_OFS;
      beat.data = {29'b0, thresh_q};
    end
  end

  // A channel counts as finished once its valid has already dropped, or
  // when it is handshaking this cycle.
  assign aw_ok = !awv_q || m_axi.awready;
  assign w_ok  = !wv_q  || m_axi.wready;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    mask_d   = mask_q;
    prio_d   = prio_q;
    thresh_d = thresh_q;
    awv_d    = awv_q;
    wv_d     = wv_q;
    done_d   = 1'b0;
    err_d    = err_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          mask_d   = en_mask_i;
          prio_d   = prio_i;
          thresh_d = thresh_i;
          err_d    = 1'b0;
          idx_d    = IDX_FIRST;
          awv_d    = 1'b1;
          wv_d     = 1'b1;
          state_d  = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        if (awv_q && m_axi.awready) awv_d = 1'b0;
        if (wv_q  && m_axi.wready)  wv_d  = 1'b0;
        if (aw_ok && w_ok)          state_d = ST_RESP;
      end

      ST_RESP: begin
        if (m_axi.bvalid) begin
          if (m_axi.bresp != AXI_RESP_OKAY || idx_q == IDX_TH) begin
            err_d   = (m_axi.bresp != AXI_RESP_OKAY);
            done_d  = 1'b1;
            idx_d   = '0;
            state_d = ST_IDLE;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            awv_d   = 1'b1;
            wv_d    = 1'b1;
            state_d = ST_ISSUE;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
        awv_d   = 1'b0;
        wv_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      mask_q   <= '0;
      prio_q   <= '0;
      thresh_q <= '0;
      awv_q    <= 1'b0;
      wv_q     <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      mask_q   <= mask_d;
      prio_q   <= prio_d;
      thresh_q <= thresh_d;
      awv_q    <= awv_d;
      wv_q     <= wv_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign busy_o = (state_q != ST_IDLE);
  assign done_o = done_q;
  assign err_o  = err_q;

  assign m_axi.awaddr  = beat.addr;
  assign m_axi.awprot  = AXI_PROT_DATA;
  assign m_axi.awvalid = awv_q;
  assign m_axi.wdata   = beat.data;
  assign m_axi.wstrb   = AXI_STRB_FULL;
  assign m_axi.wvalid  = wv_q;
  assign m_axi.bready  = (state_q == ST_RESP);

endmodule

// File: tb/tb_plic_cfg_sequencer.sv
// Directed + randomized bench: AXI slave with programmable stalls/error,
// write log compared against a list-based model of the PLIC write program.
module tb_plic_cfg_sequencer;

  localparam int          NSRC = 32;
  localparam logic [31:0] BASE = 32'h0C00_0000;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic [NSRC-1:0] en_mask = '0;
  logic [2:0]      prio_v = '0;
  logic [2:0]      thresh_v = '0;
  logic            busy, done, err;

  plic_cfg_sequencer_if axi();

  plic_cfg_sequencer #(.NUM_SRC(NSRC), .PLIC_BASE(BASE)) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .start_i  (start),
    .en_mask_i(en_mask),
    .prio_i   (prio_v),
    .thresh_i (thresh_v),
    .busy_o   (busy),
    .done_o   (done),
    .err_o    (err),
    .m_axi    (axi)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // slave configuration (written by main process only)
  int aw_dly = 0, w_dly = 0, b_dly = 0, err_at = 0;

  // slave state (written by slave process only)
  logic [31:0] aq[$], dq[$], log_a[$], log_d[$];
  int          aw_wait, w_wait, bwait, bcount, stab_viol, outst_viol;
  bit          aw_hold, w_hold, pend, b_fire, prev_busy;
  logic [31:0] aw_prev, w_prev;

  // expected write program (written by main process only)
  logic [31:0] exp_a[$], exp_d[$];

  int done_cnt = 0;
  always @(negedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // AXI slave: every decision is taken at negedge and takes effect at the
  // following posedge, so a negedge seeing valid&&ready is one handshake.
  initial begin
    axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0; axi.bresp = 2'b00;
    forever begin
      @(negedge clk);
      if (rst) begin
        axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0; axi.bresp = 2'b00;
        aq.delete(); dq.delete();
        aw_wait = 0; w_wait = 0; bwait = 0;
        aw_hold = 0; w_hold = 0; pend = 0; b_fire = 0; prev_busy = 0;
        continue;
      end
      if (busy && !prev_busy) begin
        log_a.delete(); log_d.delete(); aq.delete(); dq.delete();
        bcount = 0; stab_viol = 0; outst_viol = 0;
      end
      prev_busy = busy;
      if (b_fire) begin
        axi.bvalid = 1'b0; axi.bresp = 2'b00; b_fire = 0; pend = 0; bcount++;
      end
      if (axi.awvalid) begin
        if (aw_hold && axi.awaddr !== aw_prev) stab_viol++;
        if (aw_wait >= aw_dly) begin
          axi.awready = 1'b1; aq.push_back(axi.awaddr); aw_wait = 0; aw_hold = 0;
          if (pend) outst_viol++;
        end else begin
          axi.awready = 1'b0; aw_wait++; aw_hold = 1; aw_prev = axi.awaddr;
        end
      end else begin
        axi.awready = 1'b0; aw_hold = 0;
      end
      if (axi.wvalid) begin
        if (w_hold && axi.wdata !== w_prev) stab_viol++;
        if (w_wait >= w_dly) begin
          axi.wready = 1'b1; dq.push_back(axi.wdata); w_wait = 0; w_hold = 0;
          if (pend) outst_viol++;
        end else begin
          axi.wready = 1'b0; w_wait++; w_hold = 1; w_prev = axi.wdata;
        end
      end else begin
        axi.wready = 1'b0; w_hold = 0;
      end
      while (aq.size() > 0 && dq.size() > 0) begin
        log_a.push_back(aq.pop_front());
        log_d.push_back(dq.pop_front());
        if (pend) outst_viol++;
        pend = 1; bwait = 0;
      end
      if (pend && !axi.bvalid && !b_fire) begin
        if (bwait > b_dly) begin
          axi.bvalid = 1'b1;
          axi.bresp  = (bcount + 1 == err_at) ? 2'b10 : 2'b00;
        end else bwait++;
      end
      if (axi.bvalid && axi.bready) b_fire = 1;
    end
  end

  // Reference: the ordered list of (addr, data) writes a full sequence makes.
  task automatic build_exp(input logic [31:0] m, input logic [2:0] p, input logic [2:0] t);
    exp_a.delete(); exp_d.delete();
    for (int i = 1; i < NSRC; i++) begin
      exp_a.push_back(BASE + 32'(4 * i));
      exp_d.push_back(m[i] ? 32'(p) : 32'd0);
    end
    exp_a.push_back(BASE + 32'h0000_2000); exp_d.push_back(m & 32'hFFFF_FFFE);
    exp_a.push_back(BASE + 32'h0020_0000); exp_d.push_back(32'(t));
  endtask

  task automatic pulse_start(input logic [31:0] m, input logic [2:0] p, input logic [2:0] t);
    @(negedge clk); #1;
    en_mask = m; prio_v = p; thresh_v = t; start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    en_mask = $urandom; prio_v = 3'($urandom); thresh_v = 3'($urandom);
  endtask

  task automatic wait_done(input string tag, output logic e, output logic b);
    int n = 0;
    while (done !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
    chk({tag, " done seen"}, 32'(n < 3000), 32'd1);
    e = err; b = busy;
  endtask

  task automatic check_log(input string tag, input int n);
    chk({tag, " writes"}, 32'(log_a.size()), 32'(n));
    chk({tag, " responses"}, 32'(bcount), 32'(n));
    chk({tag, " stable"}, 32'(stab_viol), 32'd0);
    chk({tag, " outstanding"}, 32'(outst_viol), 32'd0);
    for (int i = 0; i < n && i < log_a.size(); i++) begin
      chk($sformatf("%s addr[%0d]", tag, i), log_a[i], exp_a[i]);
      chk($sformatf("%s data[%0d]", tag, i), log_d[i], exp_d[i]);
    end
  endtask

  task automatic finish_seq(input string tag, input int base, input int nexp, input logic experr);
    logic e, b;
    wait_done(tag, e, b);
    chk({tag, " err"}, 32'(e), 32'(experr));
    chk({tag, " busy@done"}, 32'(b), 32'd0);
    repeat (3) @(negedge clk);
    chk({tag, " done pulses"}, 32'(done_cnt - base), 32'd1);
    check_log(tag, nexp);
  endtask

  task automatic run_seq(input string tag, input logic [31:0] m, input logic [2:0] p,
                         input logic [2:0] t, input int nexp, input logic experr);
    int base;
    build_exp(m, p, t);
    base = done_cnt;
    pulse_start(m, p, t);
    finish_seq(tag, base, nexp, experr);
  endtask

  initial begin
    logic [31:0] m;
    logic [2:0]  p, t;
    int          base, n, cnt;
    bit          quiet;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst busy", 32'(busy), 0);
    chk("rst done", 32'(done), 0);
    chk("rst err", 32'(err), 0);
    chk("rst awvalid", 32'(axi.awvalid), 0);
    chk("rst wvalid", 32'(axi.wvalid), 0);
    chk("rst bready", 32'(axi.bready), 0);
    #1 rst = 1'b0;
    quiet = 1;
    repeat (5) begin @(negedge clk); if (axi.awvalid || axi.wvalid) quiet = 0; end
    chk("idle no traffic", 32'(quiet), 1);

    // directed full sequence, always-ready slave
    aw_dly = 0; w_dly = 0; b_dly = 0; err_at = 0;
    build_exp(32'h0000_0006, 3'd3, 3'd1);
    base = done_cnt;
    pulse_start(32'h0000_0006, 3'd3, 3'd1);
    chk("awprot", 32'(axi.awprot), 0);
    chk("wstrb", 32'(axi.wstrb), 32'hF);
    finish_seq("basic", base, NSRC + 1, 1'b0);

    // AW stalled, W immediate; then the reverse
    aw_dly = 3; w_dly = 0;
    run_seq("aw_slow", $urandom, 3'($urandom), 3'($urandom), NSRC + 1, 1'b0);
    aw_dly = 0; w_dly = 3; b_dly = 2;
    run_seq("w_slow", $urandom, 3'($urandom), 3'($urandom), NSRC + 1, 1'b0);

    // randomized stalls and configs
    for (int k = 0; k < 3; k++) begin
      aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3); b_dly = $urandom_range(0, 3);
      run_seq($sformatf("rand%0d", k), $urandom, 3'($urandom), 3'($urandom), NSRC + 1, 1'b0);
    end

    // SLVERR on the 5th write, then err clears on the next start
    aw_dly = 1; w_dly = 0; b_dly = 1; err_at = 5;
    run_seq("slverr", $urandom, 3'($urandom), 3'($urandom), 5, 1'b1);
    err_at = 0;
    m = $urandom; p = 3'($urandom); t = 3'($urandom);
    build_exp(m, p, t);
    base = done_cnt;
    pulse_start(m, p, t);
    chk("err cleared on start", 32'(err), 0);
    finish_seq("after_err", base, NSRC + 1, 1'b0);

    // start during write 10 must be ignored
    aw_dly = 0; w_dly = 1; b_dly = 0;
    m = $urandom; p = 3'($urandom); t = 3'($urandom);
    build_exp(m, p, t);
    base = done_cnt;
    pulse_start(m, p, t);
    n = 0;
    while (log_a.size() < 9 && n < 500) begin @(negedge clk); n++; end
    chk("reach write 10", 32'(n < 500), 1);
    pulse_start(~m, ~p, ~t);
    chk("busy mid start", 32'(busy), 1);
    finish_seq("mid_start", base, NSRC + 1, 1'b0);

    // reset while awvalid is high
    aw_dly = 3; w_dly = 0; b_dly = 0;
    pulse_start($urandom, 3'($urandom), 3'($urandom));
    chk("pre-rst awvalid", 32'(axi.awvalid), 1);
    #1 rst = 1'b1;
    #1;
    chk("mid rst busy", 32'(busy), 0);
    chk("mid rst done", 32'(done), 0);
    chk("mid rst err", 32'(err), 0);
    chk("mid rst awvalid", 32'(axi.awvalid), 0);
    chk("mid rst wvalid", 32'(axi.wvalid), 0);
    chk("mid rst bready", 32'(axi.bready), 0);
    @(negedge clk); #2 rst = 1'b0;
    quiet = 1;
    repeat (20) begin @(negedge clk); if (axi.awvalid || axi.wvalid || busy) quiet = 0; end
    chk("post rst quiet", 32'(quiet), 1);
    aw_dly = 0;
    run_seq("post_rst", $urandom, 3'($urandom), 3'($urandom), NSRC + 1, 1'b0);

    // source-0 enable bit must never leak out
    m = $urandom | 32'h1;
    run_seq("bit0", m, 3'($urandom_range(1, 7)), 3'($urandom), NSRC + 1, 1'b0);
    cnt = 0;
    foreach (log_a[i]) if (log_a[i] == BASE) cnt++;
    chk("src0 prio never written", 32'(cnt), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
